br_update_queue: RTL
====================

Name: br_update_queue

Overview:
- Buffers resolved-branch results from the integer execution lanes and drains them in order to the per-address (PAp) predictor's update write ports.
- Sits between the integer back-end (branch resolution) and the PAp predictor's counter/history write ports.
- Decouples bursty branch resolution from predictor write-port and bank constraints.
- Never drops a result: applies back-pressure to the back-end when it cannot accept a full lane group.

Parameters:
- INT_ISSUE_WIDTH, 2, number of enqueue lanes and of dequeue (update) lanes
- DEPTH, 8, queue entries; power of two, at least 2*INT_ISSUE_WIDTH
- ADDR_WIDTH, 32, branch instruction address width
- INSN_ADDR_BIT_WIDTH, 2, byte-offset bits dropped when forming the PHT index
- PHT_PAP_BITS, 4, PHT index width and per-address history width
- PHT_ENTRY_WIDTH, 2, saturating counter width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  synchronous discard of all queued entries
- enq_valid  in  INT_ISSUE_WIDTH  per-lane valid of resolved branch
- enq_addr  in  INT_ISSUE_WIDTH*ADDR_WIDTH  branch address per lane
- enq_exec_taken  in  INT_ISSUE_WIDTH  resolved direction
- enq_mispred  in  INT_ISSUE_WIDTH  misprediction flag
- enq_is_cond  in  INT_ISSUE_WIDTH  conditional branch flag
- enq_prev_hist  in  INT_ISSUE_WIDTH*PHT_PAP_BITS  history captured at fetch
- enq_prev_ctr  in  INT_ISSUE_WIDTH*PHT_ENTRY_WIDTH  selected counter value captured at fetch
- enq_ready  out  1  queue can accept a full lane group this cycle
- upd_valid  out  INT_ISSUE_WIDTH  update lane valid
- upd_addr, upd_exec_taken, upd_mispred, upd_is_cond, upd_prev_hist, upd_prev_ctr  out  same widths as the enq_* counterparts  entry fields to predictor
- upd_ready  in  1  predictor accepts updates this cycle; low during predictor reset sequence
- count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset values: queue empty, head=tail=0, count=0, upd_valid=0, enq_ready=1.
- Storage: circular buffer with head and tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH. count is kept separately so that full and empty are unambiguous.
- enq_ready = (DEPTH - count) >= INT_ISSUE_WIDTH, computed from registered state only; no combinational path from any input.
- Enqueue, when enq_ready=1:
  - Valid lanes are compacted in lane order (lane 0 oldest) and written at tail, tail+1, ...
  - tail advances by popcount(enq_valid).
  - If enq_ready=0, enq_valid must be 0 (sender contract). The bench asserts this; the RTL ignores such inputs.
- Dequeue: combinational view of the oldest entries.
  - upd_valid[0] = (count>=1) && upd_ready.
  - Lane k>0 is valid only if lane k-1 is valid, count>k, and PHT index(entry k) differs from the index of every lower valid lane.
  - PHT index = addr[PHT_PAP_BITS-1+INSN_ADDR_BIT_WIDTH : INSN_ADDR_BIT_WIDTH].
  - This stops same-index read-modify-write collisions within a cycle and preserves program order.
  - head advances by popcount(upd_valid) at the clock edge.
- Latency: an entry enqueued in cycle N is visible on upd lane 0 in cycle N+1 at the earliest (no bypass).
- Simultaneous enqueue and dequeue: count_next = count + enq_n - deq_n, where both terms are computed from the same-cycle values.
- Full queue: enq_ready=0 and dequeue proceeds normally. Empty queue: upd_valid=0 regardless of upd_ready.
- flush:
  - Next cycle head=tail=0 and count=0.
  - flush has priority over a same-cycle enqueue, whose entries are discarded.
  - Any dequeue in the flush cycle still completes; the outputs are valid that cycle.
- Asynchronous reset mid-operation: all state clears immediately, upd_valid drops in the same cycle, and entries are lost.
- Entry payload registers need no reset. Only pointers, count and per-entry valid bits are reset.

Decomposition:
- Shared package FetchUnitTypes holds:
  - BrUpdateEntry struct (addr, exec_taken, mispred, is_cond, prev_hist, prev_ctr)
  - PAP_PHT_IndexPath
  - the PHT index-extraction function, shared with the predictor so both compute the index identically
- One sub-module is natural: br_update_lane_select, the combinational conflict/prefix logic producing upd_valid and deq_n from the head entries.

Test Plan:
- Single branch:
  - Stimulus: lane0 enq at 0x1000, taken, upd_ready=1.
  - Required: next cycle upd_valid=01, upd_addr lane0=0x1000; the cycle after, count=0.
- Two branches, distinct index:
  - Stimulus: lanes 0/1 with 0x1000 and 0x1004.
  - Required: both drain in the same cycle, upd_valid=11.
- Two branches, same index:
  - Stimulus: lanes 0/1 with 0x1000 and 0x1040 (index 0 for both).
  - Required: cycle1 upd_valid=01 with 0x1000; cycle2 upd_valid=01 with 0x1040.
- Fill with upd_ready=0:
  - Stimulus: 4 dual-lane enqueues while upd_ready=0.
  - Required: count=8, enq_ready=0.
  - Then raise upd_ready and enqueue nothing: entries drain in order; enq_ready returns to 1 when count<=6.
- Flush with concurrent enqueue at count=5:
  - Required: next cycle count=0, upd_valid=0; the entries enqueued in the flush cycle are absent.
- Reset asserted asynchronously mid-cycle with count=3:
  - Required: upd_valid=0 and count=0 before the next clk edge; enq_ready=1 once reset is released.

Source files
------------

// File: rtl/br_update_queue_pkg.sv
// rtl/br_update_queue_pkg.sv - shared branch-update entry type and PHT index extraction
package br_update_queue_pkg;

    localparam int ADDR_WIDTH          = 32;
    localparam int INSN_ADDR_BIT_WIDTH = 2;
    localparam int PHT_PAP_BITS        = 4;
    localparam int PHT_ENTRY_WIDTH     = 2;

    typedef logic [PHT_PAP_BITS-1:0] pap_pht_index_path_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]      addr;
        logic                       exec_taken;
        logic                       mispred;
        logic                       is_cond;
        logic [PHT_PAP_BITS-1:0]    prev_hist;
        logic [PHT_ENTRY_WIDTH-1:0] prev_ctr;
    } br_update_entry_t;

    // The predictor calls this same function so both sides agree on the index.
    function automatic pap_pht_index_path_t pht_index(input logic [ADDR_WIDTH-1:0] addr);
        return addr[PHT_PAP_BITS-1+INSN_ADDR_BIT_WIDTH : INSN_ADDR_BIT_WIDTH];
    endfunction

endpackage

// File: rtl/br_update_lane_select.sv
// rtl/br_update_lane_select.sv - in-order dequeue lane selection avoiding same-index PHT collisions
module br_update_lane_select
    import br_update_queue_pkg::*;
#(
    parameter int LANES = 2,
    parameter int CNT_W = 4,
    parameter int DEQ_W = 2
) (
    input  logic [CNT_W-1:0]     count_i,
    input  logic                 upd_ready_i,
    input  pap_pht_index_path_t  head_idx_i [LANES],
    output logic [LANES-1:0]     upd_valid_o,
    output logic [DEQ_W-1:0]     deq_n_o
);

    logic prev_ok;
    logic lane_ok;

    // A lane fires only if every older lane fires and none of them hits the same PHT index.
    always_comb begin
        upd_valid_o = '0;
        deq_n_o     = '0;
        prev_ok     = 1'b1;
        lane_ok     = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            lane_ok = prev_ok && upd_ready_i && (count_i > CNT_W'(k));
            for (int j = 0; j < k; j++) begin
                if (head_idx_i[j] == head_idx_i[k]) begin
                    lane_ok = 1'b0;
                end
            end
            upd_valid_o[k] = lane_ok;
            prev_ok        = lane_ok;
            deq_n_o        = deq_n_o + DEQ_W'(lane_ok);
        end
    end

endmodule

// File: rtl/br_update_queue.sv
// rtl/br_update_queue.sv - multi-lane in-order queue of resolved branches feeding PAp predictor updates
module br_update_queue
    import br_update_queue_pkg::*;
#(
    parameter int INT_ISSUE_WIDTH = 2,
    parameter int DEPTH           = 8
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       flush,
    input  logic [INT_ISSUE_WIDTH-1:0]                 enq_valid,
    input  logic [INT_ISSUE_WIDTH*ADDR_WIDTH-1:0]      enq_addr,
    input  logic [INT_ISSUE_WIDTH-1:0]                 enq_exec_taken,
    input  logic [INT_ISSUE_WIDTH-1:0]                 enq_mispred,
    input  logic [INT_ISSUE_WIDTH-1:0]                 enq_is_cond,
    input  logic [INT_ISSUE_WIDTH*PHT_PAP_BITS-1:0]    enq_prev_hist,
    input  logic [INT_ISSUE_WIDTH*PHT_ENTRY_WIDTH-1:0] enq_prev_ctr,
    output logic                                       enq_ready,
    output logic [INT_ISSUE_WIDTH-1:0]                 upd_valid,
    output logic [INT_ISSUE_WIDTH*ADDR_WIDTH-1:0]      upd_addr,
    output logic [INT_ISSUE_WIDTH-1:0]                 upd_exec_taken,
    output logic [INT_ISSUE_WIDTH-1:0]                 upd_mispred,
    output logic [INT_ISSUE_WIDTH-1:0]                 upd_is_cond,
    output logic [INT_ISSUE_WIDTH*PHT_PAP_BITS-1:0]    upd_prev_hist,
    output logic [INT_ISSUE_WIDTH*PHT_ENTRY_WIDTH-1:0] upd_prev_ctr,
    input  logic                                       upd_ready,
    output logic [$clog2(DEPTH):0]                     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DEQ_W = $clog2(INT_ISSUE_WIDTH) + 1;

    br_update_entry_t    mem_q [DEPTH];
    logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;

    br_update_entry_t    enq_entry [INT_ISSUE_WIDTH];
    logic [PTR_W-1:0]    enq_slot  [INT_ISSUE_WIDTH];
    logic [DEQ_W-1:0]    enq_n;
    logic                enq_fire;

    br_update_entry_t    head_entry [INT_ISSUE_WIDTH];
    pap_pht_index_path_t head_idx   [INT_ISSUE_WIDTH];
    logic [DEQ_W-1:0]    deq_n;

    assign enq_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(INT_ISSUE_WIDTH);
    assign enq_fire  = enq_ready && !flush;
    assign count     = count_q;

    // Valid lanes are packed into consecutive slots starting at tail.
    always_comb begin
        enq_n = '0;
        for (int l = 0; l < INT_ISSUE_WIDTH; l++) begin
            enq_entry[l].addr       = enq_addr[l*ADDR_WIDTH +: ADDR_WIDTH];
            enq_entry[l].exec_taken = enq_exec_taken[l];
            enq_entry[l].mispred    = enq_mispred[l];
            enq_entry[l].is_cond    = enq_is_cond[l];
            enq_entry[l].prev_hist  = enq_prev_hist[l*PHT_PAP_BITS +: PHT_PAP_BITS];
            enq_entry[l].prev_ctr   = enq_prev_ctr[l*PHT_ENTRY_WIDTH +: PHT_ENTRY_WIDTH];
            enq_slot[l]             = tail_q + PTR_W'(enq_n);
            if (enq_valid[l]) begin
                enq_n = enq_n + DEQ_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int l = 0; l < INT_ISSUE_WIDTH; l++) begin
            if (enq_fire && enq_valid[l]) begin
                mem_q[enq_slot[l]] <= enq_entry[l];
            end
        end
    end

    for (genvar k = 0; k < INT_ISSUE_WIDTH; k++) begin : g_head
        assign head_entry[k] = mem_q[head_q + PTR_W'(k)];
        assign head_idx[k]   = pht_index(head_entry[k].addr);
        assign upd_addr[k*ADDR_WIDTH +: ADDR_WIDTH]                = head_entry[k].addr;
        assign upd_exec_taken[k]                                   = head_entry[k].exec_taken;
        assign upd_mispred[k]                                      = head_entry[k].mispred;
        assign upd_is_cond[k]                                      = head_entry[k].is_cond;
        assign upd_prev_hist[k*PHT_PAP_BITS +: PHT_PAP_BITS]       = head_entry[k].prev_hist;
        assign upd_prev_ctr[k*PHT_ENTRY_WIDTH +: PHT_ENTRY_WIDTH]  = head_entry[k].prev_ctr;
    end

    br_update_lane_select #(
        .LANES (INT_ISSUE_WIDTH),
        .CNT_W (CNT_W),
        .DEQ_W (DEQ_W)
    ) u_lane_select (
        .count_i     (count_q),
        .upd_ready_i (upd_ready),
        .head_idx_i  (head_idx),
        .upd_valid_o (upd_valid),
        .deq_n_o     (deq_n)
    );

    // Dequeue still completes in a flush cycle; only the pointers are forced back to zero.
    always_comb begin
        head_d  = head_q + PTR_W'(deq_n);
        tail_d  = tail_q + (enq_fire ? PTR_W'(enq_n) : '0);
        count_d = count_q + (enq_fire ? CNT_W'(enq_n) : '0) - CNT_W'(deq_n);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule
